// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Two-requester round-robin front end for a single shared combinational ALU.
// One operation is in flight at a time: IDLE (accept) -> EXEC (ALU evaluates
// registered operands) -> RESP (hold response until the owner takes it).
//
// Parameters
//   RR_INIT      requester holding round-robin priority after reset
// Ports
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   req_valid    [1:0]  per-requester request valid
//   req_ready    [1:0]  per-requester accept (IDLE only, at most one bit)
//   req_a/req_b  [63:0] operands, requester i in bits [32i+31:32i]
//   req_op       [7:0]  op codes, requester i in bits [4i+3:4i]
//   rsp_valid    [1:0]  one-hot response valid (RESP only)
//   rsp_ready    [1:0]  per-requester response accept
//   rsp_result   [31:0] shared response result
//   rsp_ovf             shared response signed-overflow flag
//   alu_srca/alu_srcb/alu_op  registered operands/op to the shared ALU
//   alu_result/alu_overflow   combinational ALU outputs
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter logic RR_INIT = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [63:0] req_a,
    input  logic [63:0] req_b,
    input  logic [7:0]  req_op,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_ovf,
    output logic [31:0] alu_srca,
    output logic [31:0] alu_srcb,
    output logic [3:0]  alu_op,
    input  logic [31:0] alu_result,
    input  logic        alu_overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic        rr_ptr_r;
    logic        owner_r;
    logic [31:0] srca_r;
    logic [31:0] srcb_r;
    logic [3:0]  op_r;
    logic [31:0] result_r;
    logic        ovf_r;
    logic [1:0]  rsp_valid_r;

    logic        grant_valid_s;
    logic        grant_s;
    logic [1:0]  ready_s;
    logic        req_hs_s;
    logic        rsp_hs_s;

    // One-hot decode of a requester index.
    function automatic logic [1:0] onehot2(input logic sel);
        return sel ? 2'b10 : 2'b01;
    endfunction

    // Grant selection: round-robin pointer only breaks ties.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_s       = rr_ptr_r;
        case (req_valid)
            2'b11: begin
                grant_valid_s = 1'b1;
                grant_s       = rr_ptr_r;
            end
            2'b10: begin
                grant_valid_s = 1'b1;
                grant_s       = 1'b1;
            end
            2'b01: begin
                grant_valid_s = 1'b1;
                grant_s       = 1'b0;
            end
            default: begin
                grant_valid_s = 1'b0;
                grant_s       = rr_ptr_r;
            end
        endcase
    end

    // Request accept: only in IDLE, and held low while reset is asserted so
    // nothing is accepted during the reset window.
    always_comb begin
        ready_s = 2'b00;
        if ((state_r == IDLE) && grant_valid_s && rst_n) begin
            ready_s = onehot2(grant_s);
        end else begin
            ready_s = 2'b00;
        end
    end

    // ready_s is only ever set on a valid requester, so any ready bit is a handshake.
    assign req_hs_s = |(ready_s & req_valid);
    assign rsp_hs_s = (state_r == RESP) && rsp_ready[owner_r];

    // Next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_hs_s) begin
                    state_next_s = EXEC;
                end else begin
                    state_next_s = IDLE;
                end
            end
            EXEC: begin
                state_next_s = RESP;
            end
            RESP: begin
                if (rsp_hs_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RESP;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State, response-valid and round-robin pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            rsp_valid_r <= 2'b00;
            rr_ptr_r    <= RR_INIT;
        end else begin
            state_r <= state_next_s;
            // owner_r is already stable when RESP is entered from EXEC.
            rsp_valid_r <= (state_next_s == RESP) ? onehot2(owner_r) : 2'b00;
            if (req_hs_s) begin
                rr_ptr_r <= ~grant_s;
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end
        end
    end

    // Operand/op/owner capture on request handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            srca_r  <= 32'h0000_0000;
            srcb_r  <= 32'h0000_0000;
            op_r    <= 4'h0;
            owner_r <= 1'b0;
        end else if (req_hs_s) begin
            srca_r  <= grant_s ? req_a[63:32] : req_a[31:0];
            srcb_r  <= grant_s ? req_b[63:32] : req_b[31:0];
            op_r    <= grant_s ? req_op[7:4]  : req_op[3:0];
            owner_r <= grant_s;
        end else begin
            srca_r  <= srca_r;
            srcb_r  <= srcb_r;
            op_r    <= op_r;
            owner_r <= owner_r;
        end
    end

    // Response capture from the ALU at the end of EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_r <= 32'h0000_0000;
            ovf_r    <= 1'b0;
        end else if (state_r == EXEC) begin
            result_r <= alu_result;
            ovf_r    <= alu_overflow;
        end else begin
            result_r <= result_r;
            ovf_r    <= ovf_r;
        end
    end

    assign req_ready  = ready_s;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_result = result_r;
    assign rsp_ovf    = ovf_r;
    assign alu_srca   = srca_r;
    assign alu_srcb   = srcb_r;
    assign alu_op     = op_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
// Directed bench for alu_arbiter. A small behavioural ALU closes the loop on
// the alu_* ports; all expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [7:0]  req_op;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_ovf;
    logic [31:0] alu_srca;
    logic [31:0] alu_srcb;
    logic [3:0]  alu_op;
    logic [31:0] alu_result;
    logic        alu_overflow;

    int checks = 0;
    int errors = 0;

    alu_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_op       (req_op),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_ovf      (rsp_ovf),
        .alu_srca     (alu_srca),
        .alu_srcb     (alu_srcb),
        .alu_op       (alu_op),
        .alu_result   (alu_result),
        .alu_overflow (alu_overflow)
    );

    always #5 clk = ~clk;

    // Shared ALU environment model.
    always_comb begin
        alu_result   = 32'h0000_0000;
        alu_overflow = 1'b0;
        case (alu_op)
            4'd0: alu_result = alu_srca << alu_srcb[4:0];
            4'd1: begin
                alu_result   = alu_srca - alu_srcb;
                alu_overflow = (alu_srca[31] != alu_srcb[31]) && (alu_result[31] != alu_srca[31]);
            end
            4'd2: alu_result = alu_srca | alu_srcb;
            4'd3: begin
                alu_result   = alu_srca + alu_srcb;
                alu_overflow = (alu_srca[31] == alu_srcb[31]) && (alu_result[31] != alu_srca[31]);
            end
            4'd4: alu_result = alu_srcb << 16;
            4'd5: alu_result = alu_srca & alu_srcb;
            4'd6: alu_result = ($signed(alu_srca) < $signed(alu_srcb)) ? 32'd1 : 32'd0;
            4'd7: alu_result = (alu_srca < alu_srcb) ? 32'd1 : 32'd0;
            default: alu_result = 32'h0000_0000;
        endcase
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to 2ns after the next rising edge (start of a new cycle).
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic idx, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op);
        req_valid = idx ? 2'b10 : 2'b01;
        req_a     = idx ? {a, 32'h0000_0000} : {32'h0000_0000, a};
        req_b     = idx ? {b, 32'h0000_0000} : {32'h0000_0000, b};
        req_op    = idx ? {op, 4'h0} : {4'h0, op};
    endtask

    // Full single-requester operation with immediate response acceptance.
    task automatic run_op(input string tag, input logic idx, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] op,
                          input logic [31:0] exp_res, input logic exp_ovf);
        logic [1:0] oh;
        oh = idx ? 2'b10 : 2'b01;
        drive(idx, a, b, op);
        rsp_ready = 2'b11;
        #1;
        check({tag, "_ready"}, {62'd0, req_ready}, {62'd0, oh});
        tick();
        req_valid = 2'b00;
        #1;
        check({tag, "_exec_rspv"}, {62'd0, rsp_valid}, 64'd0);
        check({tag, "_exec_ready"}, {62'd0, req_ready}, 64'd0);
        tick();
        #1;
        check({tag, "_rspv"}, {62'd0, rsp_valid}, {62'd0, oh});
        check({tag, "_result"}, {32'd0, rsp_result}, {32'd0, exp_res});
        check({tag, "_ovf"}, {63'd0, rsp_ovf}, {63'd0, exp_ovf});
        tick();
        #1;
        check({tag, "_idle_rspv"}, {62'd0, rsp_valid}, 64'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 2'b11;
        req_a     = 64'h0;
        req_b     = 64'h0;
        req_op    = 8'h33;
        rsp_ready = 2'b00;

        // Reset state, with requests presented during reset.
        tick();
        #1;
        check("rst_req_ready", {62'd0, req_ready}, 64'd0);
        check("rst_rsp_valid", {62'd0, rsp_valid}, 64'd0);
        check("rst_rsp_result", {32'd0, rsp_result}, 64'd0);
        check("rst_rsp_ovf", {63'd0, rsp_ovf}, 64'd0);
        check("rst_alu_srca", {32'd0, alu_srca}, 64'd0);
        check("rst_alu_op", {60'd0, alu_op}, 64'd0);
        req_valid = 2'b00;
        tick();
        rst_n = 1'b1;

        // Signed add overflow, accepted in the first cycle after reset.
        run_op("add_ovf", 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 4'd3, 32'h8000_0000, 1'b1);
        check("hold_result", {32'd0, rsp_result}, {32'd0, 32'h8000_0000});

        // Round-robin with both valid after a fresh reset.
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        req_valid = 2'b11;
        req_a     = {32'h0000_00F0, 32'h0000_0005};
        req_b     = {32'h0000_000F, 32'h0000_0003};
        req_op    = {4'd2, 4'd1};
        rsp_ready = 2'b11;
        #1;
        check("rr_first_r0", {62'd0, req_ready}, {62'd0, 2'b01});
        tick();
        #1;
        check("rr_exec_ready", {62'd0, req_ready}, 64'd0);
        tick();
        #1;
        check("rr_sub_rspv", {62'd0, rsp_valid}, {62'd0, 2'b01});
        check("rr_sub_result", {32'd0, rsp_result}, 64'd2);
        check("rr_sub_ovf", {63'd0, rsp_ovf}, 64'd0);
        tick();
        #1;
        check("rr_second_r1", {62'd0, req_ready}, {62'd0, 2'b10});
        tick();
        tick();
        #1;
        check("rr_ori_rspv", {62'd0, rsp_valid}, {62'd0, 2'b10});
        check("rr_ori_result", {32'd0, rsp_result}, 64'hFF);
        tick();
        #1;
        check("rr_back_r0", {62'd0, req_ready}, {62'd0, 2'b01});
        req_valid = 2'b00;
        #1;
        check("rr_none_ready", {62'd0, req_ready}, 64'd0);

        // Signed vs unsigned compare.
        tick();
        run_op("slt", 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 4'd6, 32'h0000_0001, 1'b0);
        run_op("sltu", 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 4'd7, 32'h0000_0000, 1'b0);

        // Response back-pressure; non-owner ready and request churn ignored.
        drive(1'b0, 32'h0000_0001, 32'h0000_0002, 4'd3);
        rsp_ready = 2'b00;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            rsp_ready = 2'b10;
            req_valid = 2'b11;
            req_a     = {32'd9, 32'd9};
            #1;
            check("bp_rspv", {62'd0, rsp_valid}, {62'd0, 2'b01});
            check("bp_result", {32'd0, rsp_result}, 64'd3);
            check("bp_ready", {62'd0, req_ready}, 64'd0);
            tick();
        end
        rsp_ready = 2'b01;
        tick();
        #1;
        check("bp_release_rspv", {62'd0, rsp_valid}, 64'd0);
        check("bp_release_ready", {62'd0, req_ready}, {62'd0, 2'b10});
        req_valid = 2'b00;
        rsp_ready = 2'b11;

        // Reset during EXEC discards the operation.
        tick();
        drive(1'b1, 32'h1234_5678, 32'h0000_0001, 4'd3);
        tick();
        req_valid = 2'b00;
        rst_n = 1'b0;
        #1;
        check("mid_rst_srca", {32'd0, alu_srca}, 64'd0);
        check("mid_rst_op", {60'd0, alu_op}, 64'd0);
        check("mid_rst_result", {32'd0, rsp_result}, 64'd0);
        check("mid_rst_rspv", {62'd0, rsp_valid}, 64'd0);
        tick();
        #1;
        check("mid_rst_rspv2", {62'd0, rsp_valid}, 64'd0);
        rst_n = 1'b1;
        #1;
        check("post_rst_rspv", {62'd0, rsp_valid}, 64'd0);
        run_op("post_rst", 1'b1, 32'h0000_0010, 32'h0000_0020, 4'd5, 32'h0000_0000, 1'b0);

        // r1 alone, continuously valid, four back-to-back operations.
        rsp_ready = 2'b11;
        drive(1'b1, 32'h0000_0004, 32'h0000_0004, 4'd3);
        for (int c = 0; c < 12; c++) begin
            #1;
            check("solo_ready", {62'd0, req_ready}, (c % 3 == 0) ? 64'd2 : 64'd0);
            check("solo_rspv", {62'd0, rsp_valid}, (c % 3 == 2) ? 64'd2 : 64'd0);
            if (c % 3 == 2) begin
                check("solo_result", {32'd0, rsp_result}, 64'd8);
            end else begin
                checks = checks;
            end
            tick();
        end
        req_valid = 2'b00;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
